// File: rtl/core_dispatch_scoreboard.sv
// ---------------------------------------------------------------------------
// core_dispatch_scoreboard
//
// Purpose: in-order dispatch decision for ISSUE_W decoded instructions per
// cycle. The block keeps its own per-register scoreboard:
//   - a 3-bit latency countdown per register for the fixed-latency EUs
//     (ALU, MUL, BRANCH link)
//   - a pending flag per register for the variable-latency load/store EU
// It sits between decode and the EU issue ports.
//
// Optional feature macro: CORE_SCOREBOARD_FWD_EN
//   When defined, a source register whose countdown is 1 (and which has no
//   load pending) is treated as ready for the RAW check only, which models
//   an EU-to-dispatch bypass. The WAW check always uses the full busy state.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        per slot: slot holds a decoded instruction
//   in_class        per slot, 2 bits: 0 ALU, 1 MUL, 2 LDST, 3 BRANCH
//   in_writeback    per slot: slot writes rd
//   in_rd           per slot destination index
//   in_uses_ra/ra   per slot source A use flag / index
//   in_uses_rb/rb   per slot source B use flag / index
//   branch_stall    blocks all dispatch this cycle
//   ldst_done       one-cycle pulse: outstanding LDST writeback completes
//   dispatch        per slot dispatch decision (combinational)
//   busy_mask       registered per-register pending-write mask
//   mul_busy        registered: multiplier cannot accept an op
//   ldst_busy       registered: an LDST op is outstanding
// ---------------------------------------------------------------------------
module core_dispatch_scoreboard #(
  parameter int ISSUE_W       = 2,
  parameter int NUM_REGS      = 16,
  parameter int REG_W         = 4,
  parameter int ALU_LAT       = 1,
  parameter int MUL_LAT       = 3,
  parameter int MUL_PIPELINED = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ISSUE_W-1:0]         in_valid,
  input  logic [2*ISSUE_W-1:0]       in_class,
  input  logic [ISSUE_W-1:0]         in_writeback,
  input  logic [REG_W*ISSUE_W-1:0]   in_rd,
  input  logic [ISSUE_W-1:0]         in_uses_ra,
  input  logic [REG_W*ISSUE_W-1:0]   in_ra,
  input  logic [ISSUE_W-1:0]         in_uses_rb,
  input  logic [REG_W*ISSUE_W-1:0]   in_rb,
  input  logic                       branch_stall,
  input  logic                       ldst_done,
  output logic [ISSUE_W-1:0]         dispatch,
  output logic [NUM_REGS-1:0]        busy_mask,
  output logic                       mul_busy,
  output logic                       ldst_busy
);

  localparam logic [1:0] CLS_ALU    = 2'd0;
  localparam logic [1:0] CLS_MUL    = 2'd1;
  localparam logic [1:0] CLS_LDST   = 2'd2;
  localparam logic [1:0] CLS_BRANCH = 2'd3;

  localparam logic [2:0] ALU_LAT_C = 3'(ALU_LAT);
  localparam logic [2:0] MUL_LAT_C = 3'(MUL_LAT);
  localparam bit         MUL_PIPE  = (MUL_PIPELINED != 0);

  // Scoreboard state
  logic [2:0]          r_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] r_ldst_pend;
  logic [NUM_REGS-1:0] r_busy_mask;
  logic [2:0]          r_mul_cnt;
  logic                r_mul_busy;
  logic                r_ldst_busy;

  // Next-state and decision signals
  logic [NUM_REGS-1:0] w_raw_busy;
  logic [ISSUE_W-1:0]  w_dispatch;
  logic [2:0]          w_cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [2:0]          w_mul_cnt_nxt;
  logic                w_ldst_busy_nxt;

  // Busy view used by the RAW check (optionally bypasses the last countdown cycle)
  always_comb begin
    w_raw_busy = r_busy_mask;
`ifdef CORE_SCOREBOARD_FWD_EN
    for (int r = 0; r < NUM_REGS; r++) begin
      // Result arrives at the end of this cycle and can be forwarded.
      w_raw_busy[r] = r_busy_mask[r] & ~((r_cnt[r] == 3'd1) & ~r_ldst_pend[r]);
    end
`endif
  end

  // In-order dispatch decision with RAW/WAW/intra-group/structural hazards
  always_comb begin
    logic             v_prev_ok;
    logic             v_blk;
    logic [1:0]       v_cls_i;
    logic [1:0]       v_cls_j;
    logic [REG_W-1:0] v_rd_i;
    logic [REG_W-1:0] v_ra_i;
    logic [REG_W-1:0] v_rb_i;
    logic [REG_W-1:0] v_rd_j;
    w_dispatch = '0;
    // The enable chain makes dispatch a strict in-order prefix.
    v_prev_ok  = rst_n & ~branch_stall;
    for (int i = 0; i < ISSUE_W; i++) begin
      v_cls_i = in_class[2*i +: 2];
      v_rd_i  = in_rd[i*REG_W +: REG_W];
      v_ra_i  = in_ra[i*REG_W +: REG_W];
      v_rb_i  = in_rb[i*REG_W +: REG_W];
      v_blk   = 1'b0;
      v_blk   = v_blk | (in_uses_ra[i] & w_raw_busy[v_ra_i]);
      v_blk   = v_blk | (in_uses_rb[i] & w_raw_busy[v_rb_i]);
      v_blk   = v_blk | (in_writeback[i] & r_busy_mask[v_rd_i]);
      v_blk   = v_blk | ((v_cls_i == CLS_MUL) & r_mul_busy);
      v_blk   = v_blk | ((v_cls_i == CLS_LDST) & r_ldst_busy);
      for (int j = 0; j < i; j++) begin
        v_cls_j = in_class[2*j +: 2];
        v_rd_j  = in_rd[j*REG_W +: REG_W];
        v_blk   = v_blk | (in_writeback[j] &
                           ((in_uses_ra[i] & (v_ra_i == v_rd_j)) |
                            (in_uses_rb[i] & (v_rb_i == v_rd_j)) |
                            (v_rd_i == v_rd_j)));
        v_blk   = v_blk | (v_cls_j == CLS_BRANCH);
        v_blk   = v_blk | ((v_cls_i == CLS_MUL)  & (v_cls_j == CLS_MUL));
        v_blk   = v_blk | ((v_cls_i == CLS_LDST) & (v_cls_j == CLS_LDST));
      end
      w_dispatch[i] = v_prev_ok & in_valid[i] & ~v_blk;
      v_prev_ok     = w_dispatch[i];
    end
  end

  assign dispatch = w_dispatch;

  // Scoreboard next state: decrement, then apply loads from dispatched slots
  always_comb begin
    logic [REG_W-1:0] v_rd;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_cnt_nxt[r] = (r_cnt[r] == 3'd0) ? 3'd0 : (r_cnt[r] - 3'd1);
    end
    w_pend_nxt      = ldst_done ? '0 : r_ldst_pend;
    // A dispatch below overrides a spurious ldst_done in the same cycle.
    w_ldst_busy_nxt = ldst_done ? 1'b0 : r_ldst_busy;
    w_mul_cnt_nxt   = (MUL_PIPE || (r_mul_cnt == 3'd0)) ? 3'd0 : (r_mul_cnt - 3'd1);
    for (int i = 0; i < ISSUE_W; i++) begin
      v_rd = in_rd[i*REG_W +: REG_W];
      case ({w_dispatch[i], in_class[2*i +: 2]})
        {1'b1, CLS_ALU}, {1'b1, CLS_BRANCH}: begin
          w_cnt_nxt[v_rd] = in_writeback[i] ? ALU_LAT_C : w_cnt_nxt[v_rd];
        end
        {1'b1, CLS_MUL}: begin
          w_cnt_nxt[v_rd] = in_writeback[i] ? MUL_LAT_C : w_cnt_nxt[v_rd];
          w_mul_cnt_nxt   = MUL_PIPE ? 3'd0 : MUL_LAT_C;
        end
        {1'b1, CLS_LDST}: begin
          w_pend_nxt[v_rd] = in_writeback[i] | w_pend_nxt[v_rd];
          w_ldst_busy_nxt  = 1'b1;
        end
        default: begin
          w_ldst_busy_nxt = w_ldst_busy_nxt;
        end
      endcase
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      w_busy_nxt[r] = (w_cnt_nxt[r] != 3'd0) | w_pend_nxt[r];
    end
  end

  // Scoreboard registers and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= 3'd0;
      end
      r_ldst_pend <= '0;
      r_busy_mask <= '0;
      r_mul_cnt   <= 3'd0;
      r_mul_busy  <= 1'b0;
      r_ldst_busy <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
      end
      r_ldst_pend <= w_pend_nxt;
      r_busy_mask <= w_busy_nxt;
      r_mul_cnt   <= w_mul_cnt_nxt;
      r_mul_busy  <= (w_mul_cnt_nxt != 3'd0);
      r_ldst_busy <= w_ldst_busy_nxt;
    end
  end

  assign busy_mask = r_busy_mask;
  assign mul_busy  = r_mul_busy;
  assign ldst_busy = r_ldst_busy;

endmodule

// File: tb/tb_core_dispatch_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_core_dispatch_scoreboard
//
// Directed bench for core_dispatch_scoreboard with default parameters
// (ISSUE_W=2, NUM_REGS=16, ALU_LAT=1, MUL_LAT=3, MUL_PIPELINED=0).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_core_dispatch_scoreboard;

  localparam int ISSUE_W  = 2;
  localparam int NUM_REGS = 16;
  localparam int REG_W    = 4;

  localparam logic [1:0] C_ALU  = 2'd0;
  localparam logic [1:0] C_MUL  = 2'd1;
  localparam logic [1:0] C_LDST = 2'd2;
  localparam logic [1:0] C_BR   = 2'd3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [ISSUE_W-1:0]       in_valid;
  logic [2*ISSUE_W-1:0]     in_class;
  logic [ISSUE_W-1:0]       in_writeback;
  logic [REG_W*ISSUE_W-1:0] in_rd;
  logic [ISSUE_W-1:0]       in_uses_ra;
  logic [REG_W*ISSUE_W-1:0] in_ra;
  logic [ISSUE_W-1:0]       in_uses_rb;
  logic [REG_W*ISSUE_W-1:0] in_rb;
  logic                     branch_stall;
  logic                     ldst_done;
  logic [ISSUE_W-1:0]       dispatch;
  logic [NUM_REGS-1:0]      busy_mask;
  logic                     mul_busy;
  logic                     ldst_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  core_dispatch_scoreboard #(
    .ISSUE_W(ISSUE_W), .NUM_REGS(NUM_REGS), .REG_W(REG_W),
    .ALU_LAT(1), .MUL_LAT(3), .MUL_PIPELINED(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_class(in_class), .in_writeback(in_writeback),
    .in_rd(in_rd), .in_uses_ra(in_uses_ra), .in_ra(in_ra),
    .in_uses_rb(in_uses_rb), .in_rb(in_rb),
    .branch_stall(branch_stall), .ldst_done(ldst_done),
    .dispatch(dispatch), .busy_mask(busy_mask),
    .mul_busy(mul_busy), .ldst_busy(ldst_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    in_valid     = '0;
    in_class     = '0;
    in_writeback = '0;
    in_rd        = '0;
    in_uses_ra   = '0;
    in_ra        = '0;
    in_uses_rb   = '0;
    in_rb        = '0;
  endtask

  task automatic set_slot(input int s, input logic [1:0] cls, input logic wb,
                          input logic [3:0] rd, input logic ura, input logic [3:0] ra,
                          input logic urb, input logic [3:0] rb);
    in_valid[s]             = 1'b1;
    in_class[2*s +: 2]      = cls;
    in_writeback[s]         = wb;
    in_rd[s*REG_W +: REG_W] = rd;
    in_uses_ra[s]           = ura;
    in_ra[s*REG_W +: REG_W] = ra;
    in_uses_rb[s]           = urb;
    in_rb[s*REG_W +: REG_W] = rb;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    branch_stall = 1'b0;
    ldst_done    = 1'b0;
    clear_in();
    set_slot(0, C_ALU, 1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 4'd0);
    #12;
    check("rst_dispatch", 32'(dispatch), 32'h0);
    check("rst_busy_mask", 32'(busy_mask), 32'h0);
    check("rst_mul_busy", 32'(mul_busy), 32'h0);
    check("rst_ldst_busy", 32'(ldst_busy), 32'h0);

    // ALU r1 at t, dependent r2 <- r1 waits in slot 0
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("alu_r1_dispatch", 32'(dispatch), 32'h1);
    next_cycle();
    clear_in();
    set_slot(0, C_ALU, 1'b1, 4'd2, 1'b1, 4'd1, 1'b0, 4'd0);
    sample();
    check("alu_r1_busy", 32'(busy_mask), 32'h0002);
`ifdef CORE_SCOREBOARD_FWD_EN
    check("raw_t1_fwd", 32'(dispatch), 32'h1);
    next_cycle();
    clear_in();
    sample();
    check("raw_t2_busy_fwd", 32'(busy_mask), 32'h0004);
`else
    check("raw_t1_wait", 32'(dispatch), 32'h0);
    next_cycle();
    sample();
    check("raw_t2_dispatch", 32'(dispatch), 32'h1);
    check("raw_t2_busy", 32'(busy_mask), 32'h0000);
`endif
    next_cycle();
    clear_in();
    next_cycle();
    next_cycle();

    // Intra-group dependency and independent pair
    set_slot(0, C_ALU, 1'b1, 4'd4, 1'b1, 4'd1, 1'b0, 4'd0);
    set_slot(1, C_ALU, 1'b1, 4'd5, 1'b1, 4'd4, 1'b0, 4'd0);
    sample();
    check("grp_dep", 32'(dispatch), 32'h1);
    next_cycle();
    clear_in();
    next_cycle();
    next_cycle();
    set_slot(0, C_ALU, 1'b1, 4'd4, 1'b1, 4'd1, 1'b0, 4'd0);
    set_slot(1, C_ALU, 1'b1, 4'd5, 1'b1, 4'd2, 1'b0, 4'd0);
    sample();
    check("grp_indep", 32'(dispatch), 32'h3);
    next_cycle();
    clear_in();
    set_slot(0, C_ALU, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0);
    sample();
    check("grp_busy", 32'(busy_mask), 32'h0030);
    check("waw_block", 32'(dispatch), 32'h0);
    next_cycle();
    clear_in();
    next_cycle();

    // Two MULs: structural hazard in group, then mul_busy for 3 cycles
    set_slot(0, C_MUL, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 4'd0);
    set_slot(1, C_MUL, 1'b1, 4'd8, 1'b0, 4'd0, 1'b0, 4'd0);
    sample();
    check("mul_pair", 32'(dispatch), 32'h1);
    check("mul_busy_pre", 32'(mul_busy), 32'h0);
    next_cycle();
    clear_in();
    set_slot(0, C_MUL, 1'b1, 4'd8, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      sample();
      check("mul_busy_hold", 32'(mul_busy), 32'h1);
      check("mul_wait", 32'(dispatch), 32'h0);
      check("mul_rd_busy", 32'(busy_mask), 32'h0040);
      next_cycle();
    end
    sample();
    check("mul_busy_free", 32'(mul_busy), 32'h0);
    check("mul_second", 32'(dispatch), 32'h1);
    check("mul_rd_free", 32'(busy_mask), 32'h0000);
    next_cycle();
    clear_in();
    repeat (4) next_cycle();

    // LDST r7, reader of r7 (via rb) waits until after ldst_done
    set_slot(0, C_LDST, 1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 4'd0);
    sample();
    check("ld_dispatch", 32'(dispatch), 32'h1);
    next_cycle();
    clear_in();
    set_slot(0, C_ALU, 1'b1, 4'd9, 1'b0, 4'd0, 1'b1, 4'd7);
    set_slot(1, C_ALU, 1'b1, 4'd10, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int k = 0; k < 5; k++) begin
      ldst_done = (k == 4);
      sample();
      check("ld_reader_wait", 32'(dispatch), 32'h0);
      check("ld_busy_hold", 32'(ldst_busy), 32'h1);
      check("ld_rd_busy", 32'(busy_mask), 32'h0080);
      next_cycle();
    end
    ldst_done = 1'b0;
    sample();
    check("ld_reader_go", 32'(dispatch), 32'h3);
    check("ld_busy_clear", 32'(ldst_busy), 32'h0);
    check("ld_rd_free", 32'(busy_mask), 32'h0000);
    next_cycle();
    clear_in();
    next_cycle();

    // Spurious ldst_done together with a no-writeback LDST dispatch
    ldst_done = 1'b1;
    set_slot(0, C_LDST, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    sample();
    check("ld_nowb_dispatch", 32'(dispatch), 32'h1);
    next_cycle();
    ldst_done = 1'b0;
    clear_in();
    set_slot(0, C_LDST, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0);
    sample();
    check("ld_nowb_busy", 32'(ldst_busy), 32'h1);
    check("ld_nowb_mask", 32'(busy_mask), 32'h0000);
    check("ld_struct_block", 32'(dispatch), 32'h0);
    ldst_done = 1'b1;
    next_cycle();
    ldst_done = 1'b0;
    sample();
    check("ld_struct_go", 32'(dispatch), 32'h1);
    next_cycle();
    clear_in();
    sample();
    check("ld_r2_pend", 32'(busy_mask), 32'h0004);
    ldst_done = 1'b1;
    next_cycle();
    ldst_done = 1'b0;
    sample();
    check("ld_r2_clear", 32'(busy_mask), 32'h0000);
    check("ld_r2_idle", 32'(ldst_busy), 32'h0);
    next_cycle();

    // Branch in slot 0 blocks slot 1
    set_slot(0, C_BR, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    set_slot(1, C_ALU, 1'b1, 4'd10, 1'b0, 4'd0, 1'b0, 4'd0);
    sample();
    check("br_group", 32'(dispatch), 32'h1);
    next_cycle();
    clear_in();

    // branch_stall blocks dispatch while counters keep running
    set_slot(0, C_MUL, 1'b1, 4'd12, 1'b0, 4'd0, 1'b0, 4'd0);
    sample();
    check("stall_pre_mul", 32'(dispatch), 32'h1);
    next_cycle();
    clear_in();
    branch_stall = 1'b1;
    set_slot(0, C_ALU, 1'b1, 4'd13, 1'b0, 4'd0, 1'b0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      sample();
      check("stall_block", 32'(dispatch), 32'h0);
      check("stall_busy", 32'(busy_mask), 32'h1000);
      next_cycle();
    end
    sample();
    check("stall_block_end", 32'(dispatch), 32'h0);
    check("stall_drained", 32'(busy_mask), 32'h0000);
    check("stall_mul_free", 32'(mul_busy), 32'h0);
    next_cycle();
    branch_stall = 1'b0;
    clear_in();

    // Branch with link writes rd with ALU latency
    set_slot(0, C_BR, 1'b1, 4'd14, 1'b0, 4'd0, 1'b0, 4'd0);
    set_slot(1, C_ALU, 1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 4'd0);
    sample();
    check("br_link_group", 32'(dispatch), 32'h1);
    next_cycle();
    clear_in();
    sample();
    check("br_link_busy", 32'(busy_mask), 32'h4000);
    next_cycle();
    next_cycle();

    // Reset in the middle of an operation
    set_slot(0, C_ALU, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
    sample();
    check("rstmid_alu", 32'(dispatch), 32'h1);
    next_cycle();
    clear_in();
    set_slot(0, C_ALU, 1'b1, 4'd15, 1'b1, 4'd3, 1'b0, 4'd0);
    sample();
    check("rstmid_busy", 32'(busy_mask), 32'h0008);
    rst_n = 1'b0;
    #1;
    check("rstmid_mask_clear", 32'(busy_mask), 32'h0000);
    check("rstmid_dispatch_off", 32'(dispatch), 32'h0);
    #2;
    rst_n = 1'b1;
    #1;
    check("rstmid_reader_go", 32'(dispatch), 32'h1);
    next_cycle();
    clear_in();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
